// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - shared FSM encoding and helpers for the game timers
package jogo_pkg;

   // Control FSM states of the countdown timer
   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      CONTANDO = 2'd1,
      PAUSADO  = 2'd2,
      EXPIRADO = 2'd3
   } estado_t;

   // Prescaler register width; a 1-bit register is kept even when P == 1
   function automatic int unsigned largura_prescaler(input int unsigned p);
      return (p > 1) ? $clog2(p) : 1;
   endfunction

endpackage

// File: rtl/divisor_tick.sv
// rtl/divisor_tick.sv - clock prescaler producing one tick every P enabled clocks
module divisor_tick
   import jogo_pkg::*;
#(
   parameter int unsigned P = 1
) (
   input  logic clock,
   input  logic zera_as_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned   W      = largura_prescaler(P);
   localparam logic [W-1:0]  ULTIMO = W'(P - 1);

   logic [W-1:0] cont_q;
   logic [W-1:0] cont_d;

   // Next phase: clear wins, otherwise advance and wrap only while enabled
   always_comb begin
      cont_d = cont_q;
      if (clr) begin
         cont_d = '0;
      end else if (en) begin
         cont_d = (cont_q == ULTIMO) ? '0 : cont_q + W'(1);
      end
   end

   // Phase register; holding when disabled preserves the phase across a pause
   always_ff @(posedge clock or negedge zera_as_n) begin
      if (!zera_as_n) begin
         cont_q <= '0;
      end else begin
         cont_q <= cont_d;
      end
   end

   assign tick = en && (cont_q == ULTIMO);

endmodule

// File: rtl/contador_regressivo_m.sv
// rtl/contador_regressivo_m.sv - loadable modulo-M countdown timer with prescaler and control FSM
module contador_regressivo_m
   import jogo_pkg::*;
#(
   parameter int unsigned M = 100,
   parameter int unsigned N = 7,
   parameter int unsigned P = 1
) (
   input  logic         clock,
   input  logic         zera_as_n,
   input  logic         zera_s,
   input  logic         carrega,
   input  logic [N-1:0] valor,
   input  logic         inicia,
   input  logic         pausa,
   output logic [N-1:0] Q,
   output logic         fim,
   output logic         meio,
   output logic         expirou,
   output logic         ativo
);

   localparam logic [N-1:0] MAXIMO = N'(M - 1);
   localparam logic [N-1:0] METADE = N'(M / 2);

   estado_t      estado_q;
   logic [N-1:0] q_q;
   logic         expirou_q;
   logic         tick_s;
   logic         presc_en;
   logic         presc_clr;
   logic [N-1:0] valor_sat;

   // The prescaler only advances on edges where the counting state survives;
   // any higher-priority command freezes (pausa) or restarts (zera_s/carrega) it
   assign presc_en  = (estado_q == CONTANDO) && !zera_s && !carrega && !pausa;
   assign presc_clr = zera_s || carrega;
   assign valor_sat = (valor > MAXIMO) ? MAXIMO : valor;

   divisor_tick #(
      .P (P)
   ) u_divisor (
      .clock     (clock),
      .zera_as_n (zera_as_n),
      .en        (presc_en),
      .clr       (presc_clr),
      .tick      (tick_s)
   );

   // Control FSM, count register and expiry pulse, priority zera_s > carrega > pausa > inicia > tick
   always_ff @(posedge clock or negedge zera_as_n) begin
      if (!zera_as_n) begin
         q_q       <= MAXIMO;
         estado_q  <= OCIOSO;
         expirou_q <= 1'b0;
      end else begin
         expirou_q <= 1'b0;
         if (zera_s) begin
            q_q      <= MAXIMO;
            estado_q <= OCIOSO;
         end else if (carrega) begin
            q_q      <= valor_sat;
            estado_q <= OCIOSO;
         end else if (pausa) begin
            if (estado_q == CONTANDO) begin
               estado_q <= PAUSADO;
            end
         end else if (inicia && (estado_q == OCIOSO || estado_q == PAUSADO)) begin
            if (q_q != '0) begin
               estado_q <= CONTANDO;
            end
         end else if (estado_q == CONTANDO && tick_s) begin
            // CONTANDO always has q_q >= 1, so the count cannot wrap below zero
            q_q <= q_q - N'(1);
            if (q_q == N'(1)) begin
               estado_q  <= EXPIRADO;
               expirou_q <= 1'b1;
            end
         end
      end
   end

   assign Q       = q_q;
   assign fim     = (q_q == '0);
   assign meio    = (q_q == METADE);
   assign expirou = expirou_q;
   assign ativo   = (estado_q == CONTANDO);

endmodule

// File: tb/tb_contador_regressivo_m.sv
// tb/tb_contador_regressivo_m.sv - self-checking bench for the countdown timer (P=3 and P=1 instances)
module tb_contador_regressivo_m;

   logic       clock = 1'b0;
   logic       zera_as_n;
   logic       zera_s;
   logic       carrega;
   logic [3:0] valor;
   logic       inicia;
   logic       pausa;

   logic [3:0] a_q, b_q;
   logic       a_fim, a_meio, a_exp, a_ativo;
   logic       b_fim, b_meio, b_exp, b_ativo;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   contador_regressivo_m #(.M(10), .N(4), .P(3)) dut_a (
      .clock(clock), .zera_as_n(zera_as_n), .zera_s(zera_s), .carrega(carrega),
      .valor(valor), .inicia(inicia), .pausa(pausa),
      .Q(a_q), .fim(a_fim), .meio(a_meio), .expirou(a_exp), .ativo(a_ativo)
   );

   contador_regressivo_m #(.M(10), .N(4), .P(1)) dut_b (
      .clock(clock), .zera_as_n(zera_as_n), .zera_s(zera_s), .carrega(carrega),
      .valor(valor), .inicia(inicia), .pausa(pausa),
      .Q(b_q), .fim(b_fim), .meio(b_meio), .expirou(b_exp), .ativo(b_ativo)
   );

   always #5 clock = ~clock;

   // Model: count value, "running" flag, clocks left until next decrement, expiry pulse
   int mq[2];
   int mrem[2];
   bit mrun[2];
   bit mpulse[2];
   int pp[2] = '{3, 1};

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic mreset();
      for (int i = 0; i < 2; i++) begin
         mq[i] = 9; mrem[i] = pp[i]; mrun[i] = 1'b0; mpulse[i] = 1'b0;
      end
   endtask

   task automatic mstep(input int i);
      mpulse[i] = 1'b0;
      if (zera_s) begin
         mq[i] = 9; mrun[i] = 1'b0; mrem[i] = pp[i];
      end else if (carrega) begin
         mq[i] = (int'(valor) > 9) ? 9 : int'(valor);
         mrun[i] = 1'b0; mrem[i] = pp[i];
      end else if (pausa) begin
         mrun[i] = 1'b0;
      end else if (inicia && !mrun[i] && mq[i] != 0) begin
         mrun[i] = 1'b1;
      end else if (mrun[i]) begin
         mrem[i]--;
         if (mrem[i] == 0) begin
            mrem[i] = pp[i];
            mq[i]--;
            if (mq[i] == 0) begin
               mrun[i] = 1'b0;
               mpulse[i] = 1'b1;
            end
         end
      end
   endtask

   initial mreset();

   // Model advances on the same edge as the DUT; async reset restores it at once
   always @(posedge clock) begin
      if (!zera_as_n) mreset();
      else for (int i = 0; i < 2; i++) mstep(i);
   end

   always @(negedge zera_as_n) mreset();

   // Per-cycle comparison of both instances against the model
   always @(posedge clock) begin
      #2;
      if (cmp_en) begin
         chk("a_q",     int'(a_q),     mq[0]);
         chk("a_fim",   int'(a_fim),   int'(mq[0] == 0));
         chk("a_meio",  int'(a_meio),  int'(mq[0] == 5));
         chk("a_exp",   int'(a_exp),   int'(mpulse[0]));
         chk("a_ativo", int'(a_ativo), int'(mrun[0]));
         chk("b_q",     int'(b_q),     mq[1]);
         chk("b_fim",   int'(b_fim),   int'(mq[1] == 0));
         chk("b_meio",  int'(b_meio),  int'(mq[1] == 5));
         chk("b_exp",   int'(b_exp),   int'(mpulse[1]));
         chk("b_ativo", int'(b_ativo), int'(mrun[1]));
      end
   end

   task automatic esperar(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic carregar(input int v);
      carrega = 1'b1; valor = 4'(v);
      @(negedge clock);
      carrega = 1'b0;
   endtask

   task automatic iniciar();
      inicia = 1'b1;
      @(negedge clock);
      inicia = 1'b0;
   endtask

   task automatic pausar();
      pausa = 1'b1;
      @(negedge clock);
      pausa = 1'b0;
   endtask

   initial begin
      zera_as_n = 1'b1; zera_s = 1'b0; carrega = 1'b0; valor = '0;
      inicia = 1'b0; pausa = 1'b0;

      // 1. async reset between edges
      @(negedge clock);
      #2 zera_as_n = 1'b0;
      #1;
      chk("rst_q",    int'(a_q), 9);
      chk("rst_fim",  int'(a_fim), 0);
      chk("rst_meio", int'(a_meio), 0);
      chk("rst_ativo", int'(a_ativo), 0);
      chk("rst_exp",  int'(a_exp), 0);
      chk("rst_bq",   int'(b_q), 9);
      @(negedge clock);
      zera_as_n = 1'b1;
      cmp_en = 1'b1;

      // 2. load 5 and count down to expiry
      carregar(5);
      chk("t2_load", int'(a_q), 5);
      chk("t2_meio", int'(a_meio), 1);
      iniciar();
      chk("t2_ativo", int'(a_ativo), 1);
      esperar(2);
      chk("t2_hold2", int'(a_q), 5);
      esperar(1);
      chk("t2_step1", int'(a_q), 4);
      esperar(11);
      chk("t2_q1", int'(a_q), 1);
      chk("t2_noexp", int'(a_exp), 0);
      esperar(1);
      chk("t2_q0", int'(a_q), 0);
      chk("t2_exp", int'(a_exp), 1);
      chk("t2_fim", int'(a_fim), 1);
      esperar(1);
      chk("t2_exp_off", int'(a_exp), 0);

      // 3. pause mid-phase at Q=3, resume finishes the remaining phase
      carregar(5);
      iniciar();
      esperar(7);
      pausar();
      chk("t3_q", int'(a_q), 3);
      esperar(10);
      chk("t3_hold", int'(a_q), 3);
      chk("t3_ativo", int'(a_ativo), 0);
      iniciar();
      esperar(1);
      chk("t3_r1", int'(a_q), 3);
      esperar(1);
      chk("t3_r2", int'(a_q), 2);

      // 4. saturating load, clear beats load, load of zero does not start
      carregar(15);
      chk("t4_sat", int'(a_q), 9);
      chk("t4_satb", int'(b_q), 9);
      carregar(2);
      iniciar();
      esperar(1);
      zera_s = 1'b1; carrega = 1'b1; valor = 4'd4;
      @(negedge clock);
      zera_s = 1'b0; carrega = 1'b0;
      chk("t4_zq", int'(a_q), 9);
      chk("t4_zativo", int'(a_ativo), 0);
      carregar(0);
      iniciar();
      chk("t4_q0", int'(a_q), 0);
      chk("t4_noact", int'(a_ativo), 0);
      esperar(3);
      chk("t4_noexp", int'(a_exp), 0);

      // 5. pause on the tick edge, then inicia while expired
      carregar(5);
      iniciar();
      esperar(2);
      pausar();
      chk("t5_notick", int'(a_q), 5);
      iniciar();
      esperar(1);
      chk("t5_r1", int'(a_q), 4);
      esperar(12);
      chk("t5_q0", int'(a_q), 0);
      chk("t5_exp", int'(a_exp), 1);
      esperar(1);
      iniciar();
      chk("t5_ign_q", int'(a_q), 0);
      chk("t5_ign_act", int'(a_ativo), 0);

      // 6. async reset in the middle of a P=1 count
      carregar(7);
      iniciar();
      esperar(2);
      chk("t6_b5", int'(b_q), 5);
      #2 zera_as_n = 1'b0;
      #1;
      chk("t6_rst_b", int'(b_q), 9);
      chk("t6_rst_bact", int'(b_ativo), 0);
      @(negedge clock);
      zera_as_n = 1'b1;
      esperar(3);
      chk("t6_idle", int'(b_q), 9);
      iniciar();
      esperar(2);
      chk("t6_resume", int'(b_q), 7);

      esperar(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
